controller: RTL and testbench
=============================

CONTROLLER -- requirements
Module: controller

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock.
REQ-002 SHALL have: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have: IRout  input  8  current instruction byte from the datapath instruction register.
REQ-004 SHALL have outputs, each 1 bit, as datapath enables or selects: IRld, TRld, MDRld, DIld, CZNld, RegWrite, pcWrite, jmpsignal, IorD, memoryread, memorywrite, WASel, WDSel, RA2Sel, ALU1Sel, ALU2Sel.
REQ-005 SHALL have: fun  output  2  ALU function code.
REQ-006 SHALL have: halted  output  1  high while in HALT.
REQ-007 Select encoding:
- IorD: 0=PC, 1=TR.
- WDSel: 0=MDR, 1=ALU.
- WASel/RA2Sel: 0=IR[3:2], 1=DI[4:3].
- ALU1Sel: 0=B, 1=zero.
- ALU2Sel: 0=MDR, 1=A.

Function
REQ-008 Decode IRout[7:5]:
- 00x: ALU reg op, fun=IR[5:4], Rd=IR[3:2], Rs=IR[1:0].
- 010: SETDI.
- 011: NOP.
- 100: LDM.
- 101: STM.
- 110: JMPC.
- 111: HLT.
REQ-009 LDM, STM and JMPC SHALL be two bytes; the 13-bit target is {IR[4:0], byte2}.
REQ-010 FSM states SHALL be FETCH, DECODE, FETCH2, MEMRD, WBM, MEMWR, ALUEX, JMP, HALT; one state per clock.
REQ-011 FETCH SHALL assert memoryread and IRld, with IorD=0 and pcWrite=1 (jmpsignal=0, so PC increments); next state DECODE.
REQ-012 DECODE next state:
- ALU op -> ALUEX.
- SETDI -> assert DIld, then FETCH.
- NOP -> FETCH.
- LDM/STM/JMPC -> FETCH2.
- HLT -> HALT.
REQ-013 FETCH2 SHALL assert memoryread and TRld with IorD=0.
- pcWrite=1 for LDM/STM.
- pcWrite=0 for JMPC.
- Next state: MEMRD (LDM), MEMWR (STM), JMP (JMPC).
REQ-014 MEMRD SHALL assert memoryread and MDRld with IorD=1; next state WBM.
REQ-015 WBM SHALL assert RegWrite with WDSel=0 and WASel=1 (R[DI[4:3]] <= MDR); next state FETCH.
REQ-016 MEMWR SHALL assert memorywrite with IorD=1 and RA2Sel=1 (writes R[DI[4:3]]); next state FETCH.
REQ-017 ALUEX SHALL assert RegWrite and CZNld with WDSel=1, WASel=0, RA2Sel=0, ALU1Sel=0, ALU2Sel=1 and fun=IR[5:4]; next state FETCH.
REQ-018 JMP SHALL assert pcWrite and jmpsignal together.
- Taken (DI[1:0] selects C/Z/N and the flag is set): PC<=TR.
- Not taken, including DI[1:0]=00: PC<=PC+1, skipping the address byte.
- Next state FETCH.
REQ-019 Latency in clocks: ALU op 3, SETDI 2, NOP 2, LDM 5, STM 4, JMPC 4.
REQ-020 Outputs SHALL be Moore-style, decoded from state plus IRout only; every output not listed for a state SHALL be 0.
REQ-021 memoryread and memorywrite SHALL never be high together; RegWrite and memorywrite SHALL never be high together.
REQ-022 IR SHALL be loaded only in FETCH, so IRout is stable from DECODE through the end of the instruction.

Reset
REQ-023 rst high SHALL immediately force state FETCH and halted=0, independent of clk.
REQ-024 While rst is high, all outputs SHALL be 0 and fun=00, including FETCH's enables.
REQ-025 Reset mid-instruction, including mid-STM, SHALL abandon the instruction with no further register or memory write.
REQ-026 The first FETCH SHALL occur on the first rising clk edge after rst falls.

Configuration
REQ-027 Macro CONTROLLER_HALT_EN SHALL control HLT handling.
- Defined: HLT enters HALT, which holds all outputs 0 and halted=1 until rst.
- Undefined: HALT state is absent, opcode 111 decodes as NOP (2 clocks), and halted is tied 0.

Verification
REQ-028 Reset then execute 0x26 (ALU, fun=10, Rd=1, Rs=2) -> FETCH, DECODE, ALUEX; ALUEX shows RegWrite=1, CZNld=1, fun=10, WDSel=1, ALU2Sel=1.
REQ-029 Execute 0x58 (SETDI DI=11000) then 0x81,0x23 (LDM 0x123) -> DIld once; MEMRD has IorD=1 and MDRld=1; WBM has RegWrite=1, WASel=1, WDSel=0; LDM takes 5 clocks.
REQ-030 Execute SETDI 0x41 (cond=01), then JMPC 0xC0,0x40 with C=1 -> PC=0x040 after JMP; repeat with C=0 -> PC = instruction address+2.
REQ-031 Execute STM 0xA0,0x10 and pulse rst during MEMWR -> memorywrite drops asynchronously; state is FETCH; no write occurs after release.
REQ-032 Execute 0xE0 -> with CONTROLLER_HALT_EN: halted=1 and pcWrite stays 0 for 20 clocks; without it: back in FETCH after 2 clocks.
REQ-033 Random instruction stream for 10k clocks -> assertions from REQ-021 never fire.

Source files
------------

// File: rtl/controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : controller_if
//  Description : Bundle between the multicycle controller and its datapath.
//                The controller receives the current instruction byte and
//                drives every load enable, mux select, memory strobe, the
//                ALU function code and the halted flag.
//  Ports (master = controller side)
//    IRout        in   8  instruction register contents
//    IRld         out  1  load instruction register
//    TRld         out  1  load target (second byte) register
//    MDRld        out  1  load memory data register
//    DIld         out  1  load DI register from IR[4:0]
//    CZNld        out  1  load C/Z/N flags from ALU
//    RegWrite     out  1  register file write enable
//    pcWrite      out  1  PC update enable
//    jmpsignal    out  1  PC update uses conditional jump target
//    IorD         out  1  memory address: 0=PC, 1=TR target
//    memoryread   out  1  memory read strobe
//    memorywrite  out  1  memory write strobe
//    WASel        out  1  write address: 0=IR[3:2], 1=DI[4:3]
//    WDSel        out  1  write data: 0=MDR, 1=ALU
//    RA2Sel       out  1  read address 2: 0=IR[3:2], 1=DI[4:3]
//    ALU1Sel      out  1  ALU operand 1: 0=B, 1=zero
//    ALU2Sel      out  1  ALU operand 2: 0=MDR, 1=A
//    fun          out  2  ALU function code
//    halted       out  1  high while halted
//  Revision    : 1.0  initial release
// ============================================================================
interface controller_if;

  logic [7:0] IRout;
  logic       IRld;
  logic       TRld;
  logic       MDRld;
  logic       DIld;
  logic       CZNld;
  logic       RegWrite;
  logic       pcWrite;
  logic       jmpsignal;
  logic       IorD;
  logic       memoryread;
  logic       memorywrite;
  logic       WASel;
  logic       WDSel;
  logic       RA2Sel;
  logic       ALU1Sel;
  logic       ALU2Sel;
  logic [1:0] fun;
  logic       halted;

  // Controller side
  modport master (
    input  IRout,
    output IRld, TRld, MDRld, DIld, CZNld, RegWrite, pcWrite, jmpsignal,
    output IorD, memoryread, memorywrite, WASel, WDSel, RA2Sel,
    output ALU1Sel, ALU2Sel, fun, halted
  );

  // Datapath side
  modport slave (
    output IRout,
    input  IRld, TRld, MDRld, DIld, CZNld, RegWrite, pcWrite, jmpsignal,
    input  IorD, memoryread, memorywrite, WASel, WDSel, RA2Sel,
    input  ALU1Sel, ALU2Sel, fun, halted
  );

endinterface
`default_nettype wire

// File: rtl/controller.sv
`default_nettype none
// ============================================================================
//  Module      : controller
//  Description : Multicycle control FSM for an 8-bit accumulator-less
//                register machine. One state per clock; outputs are a pure
//                function of the state register and the instruction byte.
//                Instruction set (IR[7:5]):
//                  00x ALU op  fun=IR[5:4] Rd=IR[3:2] Rs=IR[1:0]
//                  010 SETDI   DI <= IR[4:0]
//                  011 NOP
//                  100 LDM     R[DI[4:3]] <= M[{IR[4:0],byte2}]
//                  101 STM     M[{IR[4:0],byte2}] <= R[DI[4:3]]
//                  110 JMPC    conditional on flag picked by DI[1:0]
//                  111 HLT
//  Ports
//    clk   in   1  rising-edge clock
//    rst   in   1  asynchronous active-high reset
//    bus   master modport of controller_if (instruction in, controls out)
//  Configuration
//    CONTROLLER_HALT_EN  defined   : HLT enters HALT until reset
//                        undefined : no HALT state, HLT behaves as NOP,
//                                    halted tied low
//  Revision    : 1.0  initial release
// ============================================================================
module controller (
  input  logic         clk,
  input  logic         rst,
  controller_if.master bus
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    FETCH2 = 4'd2,
    MEMRD  = 4'd3,
    WBM    = 4'd4,
    MEMWR  = 4'd5,
    ALUEX  = 4'd6,
    JMP    = 4'd7
`ifdef CONTROLLER_HALT_EN
    ,
    HALT   = 4'd8
`endif
  } state_t;

  // Major opcodes, IR[7:5]
  localparam logic [2:0] C_OP_SETDI = 3'b010;
  localparam logic [2:0] C_OP_NOP   = 3'b011;
  localparam logic [2:0] C_OP_LDM   = 3'b100;
  localparam logic [2:0] C_OP_STM   = 3'b101;
  localparam logic [2:0] C_OP_JMPC  = 3'b110;
`ifdef CONTROLLER_HALT_EN
  localparam logic [2:0] C_OP_HLT   = 3'b111;
`endif

  state_t r_state;
  state_t w_state_next;

  // --------------------------------------------------------------------------
  // Instruction decode
  // IR is only reloaded in FETCH, so these are stable for the whole
  // instruction once DECODE is reached.
  // --------------------------------------------------------------------------
  logic [2:0] w_opc;
  logic       w_is_alu;
  logic       w_is_setdi;
  logic       w_is_ldm;
  logic       w_is_stm;
  logic       w_is_jmpc;
  logic       w_is_two_byte;
`ifdef CONTROLLER_HALT_EN
  logic       w_is_hlt;
`endif

  assign w_opc         = bus.IRout[7:5];
  assign w_is_alu      = (w_opc[2:1] == 2'b00);
  assign w_is_setdi    = (w_opc == C_OP_SETDI);
  assign w_is_ldm      = (w_opc == C_OP_LDM);
  assign w_is_stm      = (w_opc == C_OP_STM);
  assign w_is_jmpc     = (w_opc == C_OP_JMPC);
  assign w_is_two_byte = w_is_ldm | w_is_stm | w_is_jmpc;
`ifdef CONTROLLER_HALT_EN
  assign w_is_hlt      = (w_opc == C_OP_HLT);
`endif

  // Register fields are consumed by the datapath, not here.
  logic w_unused_ir;
  assign w_unused_ir = &{1'b0, bus.IRout[3:0]};

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and Moore outputs
  // --------------------------------------------------------------------------
  logic       w_irld;
  logic       w_trld;
  logic       w_mdrld;
  logic       w_dild;
  logic       w_cznld;
  logic       w_regwrite;
  logic       w_pcwrite;
  logic       w_jmpsignal;
  logic       w_iord;
  logic       w_memoryread;
  logic       w_memorywrite;
  logic       w_wasel;
  logic       w_wdsel;
  logic       w_ra2sel;
  logic       w_alu1sel;
  logic       w_alu2sel;
  logic [1:0] w_fun;
`ifdef CONTROLLER_HALT_EN
  logic       w_halted;
`endif

  always_comb begin
    w_state_next  = r_state;
    w_irld        = 1'b0;
    w_trld        = 1'b0;
    w_mdrld       = 1'b0;
    w_dild        = 1'b0;
    w_cznld       = 1'b0;
    w_regwrite    = 1'b0;
    w_pcwrite     = 1'b0;
    w_jmpsignal   = 1'b0;
    w_iord        = 1'b0;
    w_memoryread  = 1'b0;
    w_memorywrite = 1'b0;
    w_wasel       = 1'b0;
    w_wdsel       = 1'b0;
    w_ra2sel      = 1'b0;
    w_alu1sel     = 1'b0;
    w_alu2sel     = 1'b0;
    w_fun         = 2'b00;
`ifdef CONTROLLER_HALT_EN
    w_halted      = 1'b0;
`endif

    case (r_state)
      FETCH: begin
        // IR <= M[PC], PC <= PC + 1
        w_memoryread = 1'b1;
        w_irld       = 1'b1;
        w_pcwrite    = 1'b1;
        w_state_next = DECODE;
      end

      DECODE: begin
        if (w_is_alu) begin
          w_state_next = ALUEX;
        end else if (w_is_setdi) begin
          w_dild       = 1'b1;
          w_state_next = FETCH;
        end else if (w_is_two_byte) begin
          w_state_next = FETCH2;
`ifdef CONTROLLER_HALT_EN
        end else if (w_is_hlt) begin
          w_state_next = HALT;
`endif
        end else begin
          // NOP, and HLT when halting is not built in
          w_state_next = FETCH;
        end
      end

      FETCH2: begin
        // TR <= M[PC]. JMPC leaves PC on the address byte so that a
        // not-taken jump can step over it with a plain increment in JMP.
        w_memoryread = 1'b1;
        w_trld       = 1'b1;
        w_pcwrite    = ~w_is_jmpc;
        if (w_is_ldm) begin
          w_state_next = MEMRD;
        end else if (w_is_stm) begin
          w_state_next = MEMWR;
        end else begin
          w_state_next = JMP;
        end
      end

      MEMRD: begin
        // MDR <= M[target]
        w_memoryread = 1'b1;
        w_mdrld      = 1'b1;
        w_iord       = 1'b1;
        w_state_next = WBM;
      end

      WBM: begin
        // R[DI[4:3]] <= MDR
        w_regwrite   = 1'b1;
        w_wasel      = 1'b1;
        w_state_next = FETCH;
      end

      MEMWR: begin
        // M[target] <= R[DI[4:3]]
        w_memorywrite = 1'b1;
        w_iord        = 1'b1;
        w_ra2sel      = 1'b1;
        w_state_next  = FETCH;
      end

      ALUEX: begin
        // Rd <= A fun B, flags updated
        w_regwrite   = 1'b1;
        w_cznld      = 1'b1;
        w_wdsel      = 1'b1;
        w_alu2sel    = 1'b1;
        w_fun        = bus.IRout[5:4];
        w_state_next = FETCH;
      end

      JMP: begin
        // Datapath picks TR or PC+1 from the flag selected by DI[1:0]
        w_pcwrite    = 1'b1;
        w_jmpsignal  = 1'b1;
        w_state_next = FETCH;
      end

`ifdef CONTROLLER_HALT_EN
      HALT: begin
        w_halted     = 1'b1;
        w_state_next = HALT;
      end
`endif

      default: begin
        w_state_next = FETCH;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output drive. Reset masks everything combinationally so that FETCH's
  // enables are not visible while rst is held and a reset in the middle of
  // a memory write removes the strobe at once.
  // --------------------------------------------------------------------------
  assign bus.IRld        = w_irld        & ~rst;
  assign bus.TRld        = w_trld        & ~rst;
  assign bus.MDRld       = w_mdrld       & ~rst;
  assign bus.DIld        = w_dild        & ~rst;
  assign bus.CZNld       = w_cznld       & ~rst;
  assign bus.RegWrite    = w_regwrite    & ~rst;
  assign bus.pcWrite     = w_pcwrite     & ~rst;
  assign bus.jmpsignal   = w_jmpsignal   & ~rst;
  assign bus.IorD        = w_iord        & ~rst;
  assign bus.memoryread  = w_memoryread  & ~rst;
  assign bus.memorywrite = w_memorywrite & ~rst;
  assign bus.WASel       = w_wasel       & ~rst;
  assign bus.WDSel       = w_wdsel       & ~rst;
  assign bus.RA2Sel      = w_ra2sel      & ~rst;
  assign bus.ALU1Sel     = w_alu1sel     & ~rst;
  assign bus.ALU2Sel     = w_alu2sel     & ~rst;
  assign bus.fun         = w_fun         & {2{~rst}};
`ifdef CONTROLLER_HALT_EN
  assign bus.halted      = w_halted      & ~rst;
`else
  assign bus.halted      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_controller
//  Description : Bench for controller. A small behavioural datapath (PC, IR,
//                TR, MDR, DI, flags, byte memory) closes the loop around the
//                controller. Expected control vectors for each clock are
//                queued by the stimulus; a forked monitor pops and compares
//                one per falling edge while reset is low.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  controller_if bus();

  controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // --------------------------------------------------------------------------
  // Control vector bit weights:
  // {IRld,TRld,MDRld,DIld,CZNld,RegWrite,pcWrite,jmpsignal,IorD,
  //  memoryread,memorywrite,WASel,WDSel,RA2Sel,ALU1Sel,ALU2Sel,fun[1:0],halted}
  // --------------------------------------------------------------------------
  localparam logic [18:0] B_IRLD  = 19'h40000;
  localparam logic [18:0] B_TRLD  = 19'h20000;
  localparam logic [18:0] B_MDRLD = 19'h10000;
  localparam logic [18:0] B_DILD  = 19'h08000;
  localparam logic [18:0] B_CZN   = 19'h04000;
  localparam logic [18:0] B_RW    = 19'h02000;
  localparam logic [18:0] B_PCW   = 19'h01000;
  localparam logic [18:0] B_JMP   = 19'h00800;
  localparam logic [18:0] B_IORD  = 19'h00400;
  localparam logic [18:0] B_MRD   = 19'h00200;
  localparam logic [18:0] B_MWR   = 19'h00100;
  localparam logic [18:0] B_WAS   = 19'h00080;
  localparam logic [18:0] B_WDS   = 19'h00040;
  localparam logic [18:0] B_RA2   = 19'h00020;
  localparam logic [18:0] B_A2S   = 19'h00008;
  localparam logic [18:0] B_HALT  = 19'h00001;

  localparam logic [18:0] V_FETCH = B_IRLD | B_PCW | B_MRD;
  localparam logic [18:0] V_DEC   = 19'h00000;
  localparam logic [18:0] V_DECDI = B_DILD;
  localparam logic [18:0] V_F2P   = B_TRLD | B_PCW | B_MRD;
  localparam logic [18:0] V_F2J   = B_TRLD | B_MRD;
  localparam logic [18:0] V_MEMRD = B_MDRLD | B_IORD | B_MRD;
  localparam logic [18:0] V_WBM   = B_RW | B_WAS;
  localparam logic [18:0] V_MEMWR = B_MWR | B_IORD | B_RA2;
  localparam logic [18:0] V_ALU   = B_CZN | B_RW | B_WDS | B_A2S;
  localparam logic [18:0] V_JMP   = B_PCW | B_JMP;

  function automatic logic [18:0] v_alu(input logic [1:0] f);
    return V_ALU | {16'b0, f, 1'b0};
  endfunction

  function automatic logic [18:0] pack();
    return {bus.IRld, bus.TRld, bus.MDRld, bus.DIld, bus.CZNld, bus.RegWrite,
            bus.pcWrite, bus.jmpsignal, bus.IorD, bus.memoryread,
            bus.memorywrite, bus.WASel, bus.WDSel, bus.RA2Sel, bus.ALU1Sel,
            bus.ALU2Sel, bus.fun, bus.halted};
  endfunction

  // --------------------------------------------------------------------------
  // Behavioural datapath
  // --------------------------------------------------------------------------
  logic [7:0]  mem [0:8191];
  logic [12:0] pc;
  logic [7:0]  ir;
  logic [7:0]  tr;
  logic [7:0]  mdr;
  logic [4:0]  di;
  logic        cf, zf, nf;
  logic [12:0] target;
  logic [7:0]  rd_byte;
  logic        taken;
  int          wr_count   = 0;
  int          dild_count = 0;

  assign bus.IRout = ir;
  assign target    = {ir[4:0], tr};
  assign rd_byte   = mem[bus.IorD ? target : pc];

  always_comb begin
    case (di[1:0])
      2'b01:   taken = cf;
      2'b10:   taken = zf;
      2'b11:   taken = nf;
      default: taken = 1'b0;
    endcase
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pc  <= 13'd0;
      ir  <= 8'd0;
      tr  <= 8'd0;
      mdr <= 8'd0;
      di  <= 5'd0;
    end else begin
      if (bus.memoryread && bus.IRld)  ir  <= rd_byte;
      if (bus.memoryread && bus.TRld)  tr  <= rd_byte;
      if (bus.memoryread && bus.MDRld) mdr <= rd_byte;
      if (bus.DIld) begin
        di         <= ir[4:0];
        dild_count <= dild_count + 1;
      end
      if (bus.pcWrite) pc <= (bus.jmpsignal && taken) ? target : pc + 13'd1;
      if (bus.memorywrite) wr_count <= wr_count + 1;
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  logic [18:0] qv [$];
  string       qn [$];
  int          total   = 0;
  int          bad     = 0;
  logic        prot_en = 1'b0;
  int          nproto  = 0;

  task automatic push(input logic [18:0] v, input string nm);
    qv.push_back(v);
    qn.push_back(nm);
  endtask

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic monitor();
    logic [18:0] cur;
    logic [18:0] ev;
    string       nm;
    forever begin
      @(negedge clk);
      if (!rst) begin
        cur = pack();
        if (qv.size() > 0) begin
          ev = qv.pop_front();
          nm = qn.pop_front();
          total++;
          if (cur !== ev) begin
            bad++;
            $display("FAIL %s: got=%05h want=%05h", nm, cur, ev);
          end
        end
        if (prot_en) begin
          total++;
          if ((bus.memoryread && bus.memorywrite) ||
              (bus.RegWrite && bus.memorywrite)
`ifndef CONTROLLER_HALT_EN
              || bus.halted
`endif
             ) begin
            bad++;
            if (nproto < 10)
              $display("FAIL protocol t=%0t: got=%05h want no strobe clash",
                       $time, cur);
            nproto++;
          end
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int wr0;
    int dil0;
    logic [7:0] b;

    rst = 1'b0;
    cf  = 1'b1;
    zf  = 1'b0;
    nf  = 1'b0;
    #1 rst = 1'b1;
    fork
      monitor();
    join_none

    for (int a = 0; a < 8192; a++) mem[a] = 8'h00;
    mem[0]      = 8'h26;  // ALU fun=10 Rd=1 Rs=2
    mem[1]      = 8'h58;  // SETDI 11000
    mem[2]      = 8'h81;  // LDM 0x123
    mem[3]      = 8'h23;
    mem[4]      = 8'h60;  // NOP
    mem[5]      = 8'h41;  // SETDI 00001 (cond C)
    mem[6]      = 8'hC0;  // JMPC 0x040
    mem[7]      = 8'h40;
    mem[13'h40] = 8'hC0;  // JMPC 0x050, taken only if C
    mem[13'h41] = 8'h50;
    mem[13'h42] = 8'h1B;  // ALU fun=01
    mem[13'h43] = 8'h39;  // ALU fun=11
    mem[13'h44] = 8'hE0;  // HLT
    mem[13'h123] = 8'hA5;

    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", 32'(pack()), 32'h0);

    push(V_FETCH, "alu26_fetch");   push(V_DEC, "alu26_decode");
    push(v_alu(2'b10), "alu26_aluex");
    push(V_FETCH, "setdi58_fetch"); push(V_DECDI, "setdi58_decode");
    push(V_FETCH, "ldm_fetch");     push(V_DEC, "ldm_decode");
    push(V_F2P, "ldm_fetch2");      push(V_MEMRD, "ldm_memrd");
    push(V_WBM, "ldm_wbm");
    push(V_FETCH, "nop_fetch");     push(V_DEC, "nop_decode");
    push(V_FETCH, "setdi41_fetch"); push(V_DECDI, "setdi41_decode");
    push(V_FETCH, "jmpc1_fetch");   push(V_DEC, "jmpc1_decode");
    push(V_F2J, "jmpc1_fetch2");    push(V_JMP, "jmpc1_jmp");
    push(V_FETCH, "jmpc2_fetch");   push(V_DEC, "jmpc2_decode");
    push(V_F2J, "jmpc2_fetch2");    push(V_JMP, "jmpc2_jmp");
    push(V_FETCH, "alu1b_fetch");   push(V_DEC, "alu1b_decode");
    push(v_alu(2'b01), "alu1b_aluex");
    push(V_FETCH, "alu39_fetch");   push(V_DEC, "alu39_decode");
    push(v_alu(2'b11), "alu39_aluex");
    push(V_FETCH, "hlt_fetch");     push(V_DEC, "hlt_decode");
`ifdef CONTROLLER_HALT_EN
    for (int i = 0; i < 20; i++) push(B_HALT, "halt_hold");
`else
    push(V_FETCH, "hlt_as_nop_next_fetch");
`endif

    wr0  = wr_count;
    dil0 = dild_count;
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 100 && pc != 13'h040; i++) @(negedge clk);
    check("jmpc_taken_pc", 32'(pc), 32'h040);
    cf = 1'b0;
    for (int i = 0; i < 100 && pc != 13'h042 && pc != 13'h050; i++)
      @(negedge clk);
    check("jmpc_not_taken_pc", 32'(pc), 32'h042);

    for (int i = 0; i < 200 && qv.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check("queue_a_drained", 32'(qv.size()), 32'h0);
    check("dild_pulses", 32'(dild_count - dil0), 32'd2);
    check("ldm_mdr", 32'(mdr), 32'hA5);
    check("setdi_di", 32'(di), 32'h01);
    check("no_write_a", 32'(wr_count - wr0), 32'd0);
`ifdef CONTROLLER_HALT_EN
    check("still_halted", 32'(bus.halted), 32'd1);
`endif

    // ---------------- reset in the middle of a store ----------------------
    #2 rst = 1'b1;
    #1 check("rst_async_outputs", 32'(pack()), 32'h0);
    for (int a = 0; a < 8192; a++) mem[a] = 8'h00;
    mem[0] = 8'h58;  // SETDI 11000
    mem[1] = 8'hA0;  // STM 0x010
    mem[2] = 8'h10;
    push(V_FETCH, "stm_setdi_fetch"); push(V_DECDI, "stm_setdi_decode");
    push(V_FETCH, "stm_fetch");       push(V_DEC, "stm_decode");
    push(V_F2P, "stm_fetch2");        push(V_MEMWR, "stm_memwr");
    wr0 = wr_count;
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 20 && !bus.memorywrite; i++) @(negedge clk);
    check("stm_reached_memwr", 32'(bus.memorywrite), 32'd1);
    #2 rst = 1'b1;
    #1 check("stm_rst_drops_write", 32'(pack()), 32'h0);
    for (int a = 0; a < 8192; a++) mem[a] = 8'h00;
    push(V_FETCH, "post_rst_fetch"); push(V_DEC, "post_rst_decode");
    push(v_alu(2'b00), "post_rst_aluex");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) @(negedge clk);
    check("no_write_after_rst", 32'(wr_count - wr0), 32'd0);
    check("queue_b_drained", 32'(qv.size()), 32'h0);

    // ---------------- random instruction stream ---------------------------
    @(negedge clk);
    rst = 1'b1;
    for (int a = 0; a < 8192; a++) begin
      b = 8'($urandom);
`ifdef CONTROLLER_HALT_EN
      if (b[7:5] == 3'b111) b = 8'h60;
`endif
      mem[a] = b;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    prot_en = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      {cf, zf, nf} = 3'($urandom);
    end
    prot_en = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
